register_file: RTL and testbench

- Architectural register file with rename status for the out-of-order core.
- Issue stage reads rs1/rs2 values or pending ROB tags combinationally, and renames rd to the ROB tag allocated for the instruction.
- Receiving end of the reorder buffer's RF commit interface (reg_done/reg_value/reg_tag): writes committed values and retires rename entries.
- Holds a tag-to-rd table so commits need only the ROB tag.

---
 rtl/register_file_pkg.sv | 22 ++
 rtl/register_file_if.sv | 38 +++
 rtl/register_file_rf_read_port.sv | 36 +++
 rtl/register_file.sv | 80 ++++++++
 tb/tb_register_file.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file.
// Also carries the ROB opcode encoding used by the reorder buffer.
package register_file_pkg;

    localparam int ROB_WIDTH = 4;
    localparam int ROB_SIZE  = 2 ** ROB_WIDTH;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef logic [ROB_WIDTH-1:0] rob_tag_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

    typedef enum logic [1:0] {
        ROB_OP_REG    = 2'd0,
        ROB_OP_STORE  = 2'd1,
        ROB_OP_BRANCH = 2'd2,
        ROB_OP_JALR   = 2'd3
    } rob_op_e;

endpackage

// File: rtl/register_file_if.sv
// Issue, read and commit bus between the core and the register file.
// master drives requests; slave is the register file.
interface register_file_if;
    import register_file_pkg::*;

    logic     clear_signal;
    logic     issue_signal;
    reg_idx_t issue_rd;
    rob_tag_t issue_rob_tag;
    reg_idx_t rs1_addr;
    reg_idx_t rs2_addr;
    logic     rs1_busy;
    word_t    rs1_value;
    rob_tag_t rs1_tag;
    logic     rs2_busy;
    word_t    rs2_value;
    rob_tag_t rs2_tag;
    logic     reg_done;
    word_t    reg_value;
    rob_tag_t reg_tag;

    modport master (
        output clear_signal, issue_signal, issue_rd, issue_rob_tag,
        output rs1_addr, rs2_addr,
        output reg_done, reg_value, reg_tag,
        input  rs1_busy, rs1_value, rs1_tag,
        input  rs2_busy, rs2_value, rs2_tag
    );

    modport slave (
        input  clear_signal, issue_signal, issue_rd, issue_rob_tag,
        input  rs1_addr, rs2_addr,
        input  reg_done, reg_value, reg_tag,
        output rs1_busy, rs1_value, rs1_tag,
        output rs2_busy, rs2_value, rs2_tag
    );

endinterface

// File: rtl/register_file_rf_read_port.sv
// One source-operand read port: table lookup plus same-cycle
// forwarding of the value the ROB is committing right now.
module rf_read_port
    import register_file_pkg::*;
(
    input  reg_idx_t                        rs_addr,
    input  logic [REG_NUM-1:0][XLEN-1:0]      value_q,
    input  logic [REG_NUM-1:0]                busy_q,
    input  logic [REG_NUM-1:0][ROB_WIDTH-1:0] tag_q,
    input  logic                            bypass_en,
    input  rob_tag_t                        reg_tag,
    input  word_t                           reg_value,
    output logic                            rs_busy,
    output word_t                           rs_value,
    output rob_tag_t                        rs_tag
);

    // x0 is hard zero; a pending source resolves if its producer commits now
    always_comb begin
        rs_busy  = 1'b0;
        rs_value = '0;
        rs_tag   = '0;
        if (rs_addr != '0) begin
            rs_tag   = tag_q[rs_addr];
            rs_value = value_q[rs_addr];
            if (busy_q[rs_addr]) begin
                if (bypass_en && (reg_tag == tag_q[rs_addr])) begin
                    rs_value = reg_value;
                end else begin
                    rs_busy = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename status and a tag-to-rd
// table so the ROB can commit by tag alone.
module register_file
    import register_file_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    register_file_if.slave rf
);

    logic [REG_NUM-1:0][XLEN-1:0]      value_q;
    logic [REG_NUM-1:0]                busy_q;
    logic [REG_NUM-1:0][ROB_WIDTH-1:0] tag_q;
    logic [ROB_SIZE-1:0][REG_IDX_W-1:0] dest_q;

    reg_idx_t commit_rd;
    logic     bypass_en;
    logic     commit_en;
    logic     issue_en;

    assign commit_rd = dest_q[rf.reg_tag];
    assign bypass_en = rdy_in & rf.reg_done;
    assign commit_en = bypass_en & (commit_rd != '0);
    assign issue_en  = rdy_in & rf.issue_signal & ~rf.clear_signal;

    // Commit first, then issue (a new rename wins), then flush clears busy
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
            dest_q  <= '0;
        end else begin
            if (commit_en) begin
                value_q[commit_rd] <= rf.reg_value;
                if (busy_q[commit_rd] && (tag_q[commit_rd] == rf.reg_tag)) begin
                    busy_q[commit_rd] <= 1'b0;
                end
            end
            if (issue_en) begin
                dest_q[rf.issue_rob_tag] <= rf.issue_rd;
                if (rf.issue_rd != '0) begin
                    busy_q[rf.issue_rd] <= 1'b1;
                    tag_q[rf.issue_rd]  <= rf.issue_rob_tag;
                end
            end
            if (rdy_in && rf.clear_signal) begin
                busy_q <= '0;
            end
        end
    end

    rf_read_port u_rd1 (
        .rs_addr   (rf.rs1_addr),
        .value_q   (value_q),
        .busy_q    (busy_q),
        .tag_q     (tag_q),
        .bypass_en (bypass_en),
        .reg_tag   (rf.reg_tag),
        .reg_value (rf.reg_value),
        .rs_busy   (rf.rs1_busy),
        .rs_value  (rf.rs1_value),
        .rs_tag    (rf.rs1_tag)
    );

    rf_read_port u_rd2 (
        .rs_addr   (rf.rs2_addr),
        .value_q   (value_q),
        .busy_q    (busy_q),
        .tag_q     (tag_q),
        .bypass_en (bypass_en),
        .reg_tag   (rf.reg_tag),
        .reg_value (rf.reg_value),
        .rs_busy   (rf.rs2_busy),
        .rs_value  (rf.rs2_value),
        .rs_tag    (rf.rs2_tag)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed vector table for the rename/commit corner cases, then
// random traffic checked against an array-based reference model.
module tb_register_file;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;

    register_file_if rf_if ();

    register_file dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rf     (rf_if.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    logic [31:0] m_val [32];
    logic        m_busy[32];
    logic [3:0]  m_tag [32];
    logic [4:0]  m_dest[16];

    typedef struct {
        logic        rdy, clr, iss;
        logic [4:0]  rd;
        logic [3:0]  itag;
        logic        done;
        logic [31:0] rval;
        logic [3:0]  rtag;
        logic [4:0]  rs1, rs2;
        logic        b1;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic        b2;
        logic [31:0] v2;
        logic [3:0]  t2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rdy, clr, iss, input logic [4:0] rd, input logic [3:0] itag,
        input logic done, input logic [31:0] rval, input logic [3:0] rtag,
        input logic [4:0] rs1, rs2,
        input logic b1, input logic [31:0] v1, input logic [3:0] t1,
        input logic b2, input logic [31:0] v2, input logic [3:0] t2);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.iss = iss; v.rd = rd; v.itag = itag;
        v.done = done; v.rval = rval; v.rtag = rtag;
        v.rs1 = rs1; v.rs2 = rs2;
        v.b1 = b1; v.v1 = v1; v.t1 = t1;
        v.b2 = b2; v.v2 = v2; v.t2 = t2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, rdy, clr, iss, input logic [4:0] rd,
                         input logic [3:0] itag, input logic done,
                         input logic [31:0] rval, input logic [3:0] rtag,
                         input logic [4:0] a1, a2);
        rst_in = rst;
        rdy_in = rdy;
        rf_if.clear_signal  = clr;
        rf_if.issue_signal  = iss;
        rf_if.issue_rd      = rd;
        rf_if.issue_rob_tag = itag;
        rf_if.reg_done      = done;
        rf_if.reg_value     = rval;
        rf_if.reg_tag       = rtag;
        rf_if.rs1_addr      = a1;
        rf_if.rs2_addr      = a2;
        #1;
    endtask

    // what a read of register a should return given current inputs
    task automatic model_read(input logic [4:0] a, output logic b,
                              output logic [31:0] v, output logic [3:0] t);
        b = 1'b0; v = 32'd0; t = 4'd0;
        if (a != 5'd0) begin
            t = m_tag[a];
            v = m_val[a];
            if (m_busy[a]) begin
                if (rdy_in && rf_if.reg_done && rf_if.reg_tag == m_tag[a])
                    v = rf_if.reg_value;
                else
                    b = 1'b1;
            end
        end
    endtask

    // advance model by one clock using the inputs held this cycle
    task automatic model_step();
        logic [4:0] d;
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            for (int i = 0; i < 16; i++) m_dest[i] = '0;
        end else if (rdy_in) begin
            d = m_dest[rf_if.reg_tag];
            if (rf_if.reg_done && d != 5'd0) begin
                m_val[d] = rf_if.reg_value;
                if (m_busy[d] && m_tag[d] == rf_if.reg_tag) m_busy[d] = 1'b0;
            end
            if (rf_if.issue_signal && !rf_if.clear_signal) begin
                m_dest[rf_if.issue_rob_tag] = rf_if.issue_rd;
                if (rf_if.issue_rd != 5'd0) begin
                    m_busy[rf_if.issue_rd] = 1'b1;
                    m_tag[rf_if.issue_rd]  = rf_if.issue_rob_tag;
                end
            end
            if (rf_if.clear_signal)
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic check_port(input string nm, input logic [4:0] a,
                              input logic ab, input logic [31:0] av, input logic [3:0] at,
                              input logic eb, input logic [31:0] ev, input logic [3:0] et);
        chk({nm, "_busy"}, 32'(ab), 32'(eb));
        if (!eb) chk({nm, "_value"}, av, ev);
        if (eb || a == 5'd0) chk({nm, "_tag"}, 32'(at), 32'(et));
    endtask

    initial begin
        logic b; logic [31:0] v; logic [3:0] t;

        // reset
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        //         rdy clr iss rd  itg dn rval      rtg rs1 rs2 b1 v1        t1 b2 v2        t2
        vecs.push_back(mk(1,0,1, 0, 3, 0,32'h0,     0,  5, 0, 0,32'h0,    0, 0,32'h0,    0));
        vecs.push_back(mk(1,0,0, 0, 0, 1,32'hDEAD,  3,  0, 0, 0,32'h0,    0, 0,32'h0,    0));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  0, 5, 0,32'h0,    0, 0,32'h0,    0));
        vecs.push_back(mk(1,0,1, 7, 2, 0,32'h0,     0,  7, 7, 0,32'h0,    0, 0,32'h0,    0));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  7, 7, 1,32'h0,    2, 1,32'h0,    2));
        vecs.push_back(mk(1,0,0, 0, 0, 1,32'h1234,  2,  7, 7, 0,32'h1234, 2, 0,32'h1234, 2));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  7, 0, 0,32'h1234, 2, 0,32'h0,    0));
        vecs.push_back(mk(1,0,1, 4, 1, 0,32'h0,     0,  4, 7, 0,32'h0,    0, 0,32'h1234, 2));
        vecs.push_back(mk(1,0,1, 4, 5, 0,32'h0,     0,  4, 4, 1,32'h0,    1, 1,32'h0,    1));
        vecs.push_back(mk(1,0,0, 0, 0, 1,32'hAA,    1,  4, 7, 1,32'h0,    5, 0,32'h1234, 2));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  4, 0, 1,32'hAA,   5, 0,32'h0,    0));
        vecs.push_back(mk(1,0,0, 0, 0, 1,32'hBB,    5,  4, 4, 0,32'hBB,   5, 0,32'hBB,   5));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  4, 7, 0,32'hBB,   5, 0,32'h1234, 2));
        vecs.push_back(mk(1,0,1, 9, 0, 0,32'h0,     0,  9, 0, 0,32'h0,    0, 0,32'h0,    0));
        vecs.push_back(mk(1,0,1, 9, 6, 1,32'h55,    0,  9, 9, 0,32'h55,   0, 0,32'h55,   0));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  9, 4, 1,32'h0,    6, 0,32'hBB,   5));
        vecs.push_back(mk(1,0,1, 1, 0, 0,32'h0,     0,  1, 0, 0,32'h0,    0, 0,32'h0,    0));
        vecs.push_back(mk(1,0,1, 2, 1, 0,32'h0,     0,  1, 0, 1,32'h0,    0, 0,32'h0,    0));
        vecs.push_back(mk(1,0,1, 3, 2, 0,32'h0,     0,  1, 2, 1,32'h0,    0, 1,32'h0,    1));
        vecs.push_back(mk(1,1,1, 8, 3, 1,32'h100,   0,  1, 3, 0,32'h100,  0, 1,32'h0,    2));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  1, 2, 0,32'h100,  0, 0,32'h0,    1));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  3, 8, 0,32'h0,    2, 0,32'h0,    0));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0,  9, 3, 0,32'h55,   6, 0,32'h0,    2));
        vecs.push_back(mk(1,0,1,10, 4, 0,32'h0,     0, 10, 1, 0,32'h0,    0, 0,32'h100,  0));
        vecs.push_back(mk(0,0,1,11, 7, 1,32'h77,    4, 10,11, 1,32'h0,    4, 0,32'h0,    0));
        vecs.push_back(mk(0,1,1,11, 7, 1,32'h77,    4, 10,11, 1,32'h0,    4, 0,32'h0,    0));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0, 10,11, 1,32'h0,    4, 0,32'h0,    0));
        vecs.push_back(mk(1,0,0, 0, 0, 1,32'h77,    4, 10, 1, 0,32'h77,   4, 0,32'h100,  0));
        vecs.push_back(mk(1,0,0, 0, 0, 0,32'h0,     0, 10,11, 0,32'h77,   4, 0,32'h0,    0));

        foreach (vecs[i]) begin
            drive(0, vecs[i].rdy, vecs[i].clr, vecs[i].iss, vecs[i].rd, vecs[i].itag,
                  vecs[i].done, vecs[i].rval, vecs[i].rtag, vecs[i].rs1, vecs[i].rs2);
            check_port($sformatf("v%0d_rs1", i), vecs[i].rs1,
                       rf_if.rs1_busy, rf_if.rs1_value, rf_if.rs1_tag,
                       vecs[i].b1, vecs[i].v1, vecs[i].t1);
            check_port($sformatf("v%0d_rs2", i), vecs[i].rs2,
                       rf_if.rs2_busy, rf_if.rs2_value, rf_if.rs2_tag,
                       vecs[i].b2, vecs[i].v2, vecs[i].t2);
            step();
        end

        // random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1,
                  5'($urandom), 4'($urandom),
                  $urandom_range(0, 9) < 4,
                  $urandom, 4'($urandom),
                  5'($urandom), 5'($urandom));
            model_read(rf_if.rs1_addr, b, v, t);
            check_port("rnd_rs1", rf_if.rs1_addr,
                       rf_if.rs1_busy, rf_if.rs1_value, rf_if.rs1_tag, b, v, t);
            model_read(rf_if.rs2_addr, b, v, t);
            check_port("rnd_rs2", rf_if.rs2_addr,
                       rf_if.rs2_busy, rf_if.rs2_value, rf_if.rs2_tag, b, v, t);
            step();
        end

        // sweep every register once more with the bus idle
        for (int r = 0; r < 32; r++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'(r), 5'(31 - r));
            model_read(5'(r), b, v, t);
            check_port("sweep_rs1", 5'(r),
                       rf_if.rs1_busy, rf_if.rs1_value, rf_if.rs1_tag, b, v, t);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
